snake_game_ctrl: RTL and testbench
==================================

Name: snake_game_ctrl

Overview:
- Top-level game sequencer for the snake game.
- Owns the game_state FSM, the BCD score/high-score counters, and the speed-scaled snake movement tick.
- Drives the 8-digit seven-segment display controller: high score on the upper 4 digits, current score on the lower 4.
- Sits between debounced button pulses / collision logic and the movement and display datapaths.

Parameters:
TICK_BASE, 25000000, movement tick period in clk cycles at level 0
TICK_STEP, 2000000, period reduction per level
MAX_LEVEL, 8, level saturation value; TICK_BASE - MAX_LEVEL*TICK_STEP must be >= 2
FOODS_PER_LEVEL, 5, foods eaten per level increment
BLINK_DIV, 12500000, half-period of display blink in clk cycles (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_start  in  1  one-cycle pulse, already debounced
btn_pause  in  1  one-cycle pulse, already debounced
get_food  in  1  one-cycle pulse: snake head reached food
collision  in  1  one-cycle pulse: wall or self hit
game_state  out  2  00 IDLE, 01 PLAY, 11 PAUSE, 10 OVER
move_tick  out  1  one-cycle pulse: advance snake one cell
score_bcd  out  16  current score, 4 BCD digits
high_bcd  out  16  high score, 4 BCD digits
level  out  4  current speed level
disp_hexs  out  32  {high_bcd, score_bcd} to display controller
disp_LEs  out  8  per-digit blank enable (1 = blank) to display controller

Behaviour:
- Reset (rst low, async): game_state=IDLE, score_bcd=0, high_bcd=0, level=0, move_tick=0, tick counter=0, disp_LEs=0, food counter=0.
- All outputs registered; an input pulse in cycle N is reflected in outputs in cycle N+1.
- FSM:
  - IDLE + btn_start -> PLAY. Clears score, level, food counter, tick counter.
  - PLAY + collision -> OVER.
  - PLAY + btn_pause (no collision) -> PAUSE.
  - PAUSE + btn_pause -> PLAY.
  - OVER + btn_start -> IDLE.
  - All other input/state combinations are ignored; btn_start is ignored in PLAY and PAUSE.
- Simultaneous events in PLAY: collision has priority. Any get_food or btn_pause in the same cycle is discarded; score is not incremented.
- Score:
  - get_food in PLAY increments score_bcd as a decimal counter with digit carry (0009->0010, 0999->1000).
  - Saturates at 9999.
  - get_food outside PLAY is ignored.
- Level:
  - Food counter counts get_food in PLAY, 0..FOODS_PER_LEVEL-1.
  - On wrap, level increments, saturating at MAX_LEVEL.
  - The food counter keeps wrapping after saturation.
- High score: on the PLAY->OVER transition, if score_bcd > high_bcd then high_bcd <= score_bcd, visible in the first OVER cycle. Cleared only by rst.
- Movement tick:
  - Period P = TICK_BASE - level*TICK_STEP.
  - Counter runs only in PLAY and holds its value in PAUSE.
  - move_tick pulses for 1 cycle when counter == P-1; counter returns to 0 that cycle.
  - If level changes mid-period and counter >= new P-1, the tick fires next cycle and counter returns to 0.
  - move_tick is always 0 outside PLAY.
- Display: disp_hexs = {high_bcd, score_bcd} combinationally from registers. disp_LEs = 8'h00 unless the optional feature is enabled.
- Reset mid-game: immediate return to IDLE; high score is lost.

Optional Feature:
SNAKE_CTRL_BLINK_EN
- Defined:
  - A blink counter toggles a phase bit every BLINK_DIV cycles while in PAUSE or OVER.
  - disp_LEs = 8'h0F when the phase bit is set (score digits blank), else 8'h00.
  - Phase and counter clear on entering PAUSE/OVER and in all other states, so the first BLINK_DIV cycles show digits.
- Undefined: no blink logic; disp_LEs tied to 8'h00.

Test Plan:
- Bench parameters for all scenarios: TICK_BASE=10, TICK_STEP=2, MAX_LEVEL=3, FOODS_PER_LEVEL=2, BLINK_DIV=4.
- rst low mid-PLAY with score 0005 -> game_state=00, score_bcd=0, high_bcd=0, move_tick=0, async (before next clk edge).
- btn_start in IDLE, then 30 idle cycles -> game_state=01 next cycle; move_tick pulses every 10 cycles (3 pulses).
- 7 get_food pulses in PLAY -> score_bcd=0x0007, level=3 (saturated), tick period 4. Repeat with score preset to 0x0999: one get_food -> 0x1000. At 0x9999: one get_food -> stays 0x9999.
- btn_pause at tick counter 6, wait 20 cycles, btn_pause -> no move_tick in PAUSE; first tick 4 cycles after resume (level 0).
- get_food and collision in the same cycle with score 0003 -> game_state=10, score_bcd stays 0x0003, high_bcd=0x0003. Next game reaching 0x0002 then collision -> high_bcd stays 0x0003.
- SNAKE_CTRL_BLINK_EN defined, enter OVER -> disp_LEs 00 for 4 cycles, 0F for 4, 00 for 4; btn_start -> IDLE, disp_LEs=00.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
//
// Top-level sequencer for the snake game. Owns the game-state FSM, the BCD
// score / high-score counters, the food-driven speed level and the movement
// tick whose period shrinks as the level rises. Feeds the 8-digit seven-segment
// controller with {high score, score}.
//
// Optional feature: define SNAKE_CTRL_BLINK_EN to blink the lower four (score)
// digits with half-period BLINK_DIV while paused or game over. Without the
// macro disp_les_o is tied to 8'h00.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   btn_start_i    debounced one-cycle start pulse
//   btn_pause_i    debounced one-cycle pause pulse
//   get_food_i     one-cycle pulse, snake head reached food
//   collision_i    one-cycle pulse, wall or self hit
//   game_state_o   00 idle, 01 play, 11 pause, 10 over
//   move_tick_o    one-cycle pulse, advance snake one cell
//   score_bcd_o    current score, 4 BCD digits
//   high_bcd_o     high score, 4 BCD digits
//   level_o        current speed level
//   disp_hexs_o    {high_bcd_o, score_bcd_o}
//   disp_les_o     per-digit blank enable (1 = blank)
// ---------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int unsigned TICK_BASE       = 25000000,
    parameter int unsigned TICK_STEP       = 2000000,
    parameter int unsigned MAX_LEVEL       = 8,
    parameter int unsigned FOODS_PER_LEVEL = 5,
    parameter int unsigned BLINK_DIV       = 12500000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        btn_start_i,
    input  logic        btn_pause_i,
    input  logic        get_food_i,
    input  logic        collision_i,
    output logic [1:0]  game_state_o,
    output logic        move_tick_o,
    output logic [15:0] score_bcd_o,
    output logic [15:0] high_bcd_o,
    output logic [3:0]  level_o,
    output logic [31:0] disp_hexs_o,
    output logic [7:0]  disp_les_o
);

    localparam int unsigned TickW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
    localparam int unsigned FoodW = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

    // Elaboration-time sanity check: the shortest period must still be >= 2.
    if ((TICK_BASE < MAX_LEVEL * TICK_STEP + 2) || (BLINK_DIV == 0) ||
        (FOODS_PER_LEVEL == 0) || (MAX_LEVEL > 15)) begin : gen_bad_cfg
        $error("snake_game_ctrl: illegal parameter combination");
    end

    // Encodings are the externally visible game_state values.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StOver  = 2'b10,
        StPause = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [15:0]        high_q, high_d;
    logic [3:0]         level_q, level_d;
    logic [FoodW-1:0]   food_q, food_d;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic               move_tick_q, move_tick_d;
    logic [TickW-1:0]   tick_lim;
    logic               play_live;

    // Decimal increment with digit carry, saturating at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (btn_start_i) state_d = StPlay;
            StPlay: begin
                if (collision_i) begin
                    state_d = StOver;
                end else if (btn_pause_i) begin
                    state_d = StPause;
                end
            end
            StPause: if (btn_pause_i) state_d = StPlay;
            StOver:  if (btn_start_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: datapath / registered outputs ----------------
    // Tick limit uses the current level, so a level step that leaves the
    // counter beyond the new limit fires the tick on the following cycle.
    always_comb begin
        tick_lim = TickW'(32'(TICK_BASE) - 32'(TICK_STEP) * {28'd0, level_q} - 32'd1);
    end

    // Collision wins over food and pause in the same cycle.
    assign play_live = (state_q == StPlay) && !collision_i;

    always_comb begin
        score_d     = score_q;
        high_d      = high_q;
        level_d     = level_q;
        food_d      = food_q;
        tick_cnt_d  = tick_cnt_q;
        move_tick_d = 1'b0;

        if (state_q == StIdle && btn_start_i) begin
            score_d    = '0;
            level_d    = '0;
            food_d     = '0;
            tick_cnt_d = '0;
        end

        // BCD digits compare in the same order as the binary encoding.
        if (state_q == StPlay && collision_i && (score_q > high_q)) begin
            high_d = score_q;
        end

        if (play_live && get_food_i) begin
            score_d = bcd_inc(score_q);
            if (food_q == FoodW'(FOODS_PER_LEVEL - 1)) begin
                food_d = '0;
                if (level_q < 4'(MAX_LEVEL)) begin
                    level_d = level_q + 4'd1;
                end
            end else begin
                food_d = food_q + 1'b1;
            end
        end

        // Counter only advances on cycles that stay in play; it holds across pause.
        if (play_live && !btn_pause_i) begin
            if (tick_cnt_q >= tick_lim) begin
                tick_cnt_d  = '0;
                move_tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            score_q     <= '0;
            high_q      <= '0;
            level_q     <= '0;
            food_q      <= '0;
            tick_cnt_q  <= '0;
            move_tick_q <= 1'b0;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            level_q     <= level_d;
            food_q      <= food_d;
            tick_cnt_q  <= tick_cnt_d;
            move_tick_q <= move_tick_d;
        end
    end

`ifdef SNAKE_CTRL_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;

    // Runs only while staying in pause/over; any entry or exit restarts it
    // so the first half-period always shows the digits.
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if ((state_q == StPause || state_q == StOver) && state_d == state_q) begin
            phase_d = phase_q;
            if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign disp_les_o = phase_q ? 8'h0F : 8'h00;
`else
    assign disp_les_o = 8'h00;
`endif

    assign game_state_o = state_q;
    assign move_tick_o  = move_tick_q;
    assign score_bcd_o  = score_q;
    assign high_bcd_o   = high_q;
    assign level_o      = level_q;
    assign disp_hexs_o  = {high_q, score_q};

endmodule

// File: tb/tb_snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_game_ctrl
//
// Self-checking bench for snake_game_ctrl. A decimal-arithmetic model of the
// game rules runs alongside the DUT and every output is compared on each
// falling clock edge; directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_snake_game_ctrl;

    localparam int unsigned TB_BASE  = 10;
    localparam int unsigned TB_STEP  = 2;
    localparam int unsigned TB_MAXL  = 3;
    localparam int unsigned TB_FPL   = 2;
    localparam int unsigned TB_BLINK = 4;

    localparam logic [1:0] GsIdle  = 2'b00;
    localparam logic [1:0] GsPlay  = 2'b01;
    localparam logic [1:0] GsPause = 2'b11;
    localparam logic [1:0] GsOver  = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        btn_start_i = 1'b0;
    logic        btn_pause_i = 1'b0;
    logic        get_food_i = 1'b0;
    logic        collision_i = 1'b0;
    logic [1:0]  game_state_o;
    logic        move_tick_o;
    logic [15:0] score_bcd_o;
    logic [15:0] high_bcd_o;
    logic [3:0]  level_o;
    logic [31:0] disp_hexs_o;
    logic [7:0]  disp_les_o;

    int total = 0;
    int bad   = 0;

    snake_game_ctrl #(
        .TICK_BASE       (TB_BASE),
        .TICK_STEP       (TB_STEP),
        .MAX_LEVEL       (TB_MAXL),
        .FOODS_PER_LEVEL (TB_FPL),
        .BLINK_DIV       (TB_BLINK)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .btn_start_i  (btn_start_i),
        .btn_pause_i  (btn_pause_i),
        .get_food_i   (get_food_i),
        .collision_i  (collision_i),
        .game_state_o (game_state_o),
        .move_tick_o  (move_tick_o),
        .score_bcd_o  (score_bcd_o),
        .high_bcd_o   (high_bcd_o),
        .level_o      (level_o),
        .disp_hexs_o  (disp_hexs_o),
        .disp_les_o   (disp_les_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (plain integers) ----------------
    logic [1:0] m_st    = GsIdle;
    int         m_score = 0;
    int         m_high  = 0;
    int         m_level = 0;
    int         m_food  = 0;
    int         m_cnt   = 0;
    bit         m_tick  = 0;
    int         m_blink = 0;
    bit         m_phase = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_st = GsIdle; m_score = 0; m_high = 0; m_level = 0; m_food = 0;
        m_cnt = 0; m_tick = 0; m_blink = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit st, input bit pa, input bit fd, input bit co);
        logic [1:0] nst;
        int         period;
        bit         tk;
        nst = m_st;
        tk  = 0;
        if (m_st == GsIdle) begin
            if (st) begin
                nst = GsPlay; m_score = 0; m_level = 0; m_food = 0; m_cnt = 0;
            end
        end else if (m_st == GsPlay) begin
            if (co) begin
                nst = GsOver;
                if (m_score > m_high) m_high = m_score;
            end else begin
                period = int'(TB_BASE) - m_level * int'(TB_STEP);
                if (fd) begin
                    if (m_score < 9999) m_score++;
                    m_food++;
                    if (m_food == int'(TB_FPL)) begin
                        m_food = 0;
                        if (m_level < int'(TB_MAXL)) m_level++;
                    end
                end
                if (pa) begin
                    nst = GsPause;
                end else if (m_cnt >= period - 1) begin
                    tk = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (m_st == GsPause) begin
            if (pa) nst = GsPlay;
        end else begin
            if (st) nst = GsIdle;
        end
        if ((m_st == GsPause || m_st == GsOver) && nst == m_st) begin
            m_blink++;
            if (m_blink == int'(TB_BLINK)) begin
                m_blink = 0; m_phase = !m_phase;
            end
        end else begin
            m_blink = 0; m_phase = 0;
        end
        m_tick = tk;
        m_st   = nst;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) model_reset();
        else model_step(btn_start_i, btn_pause_i, get_food_i, collision_i);
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk_i) begin
        logic [7:0] exp_les;
`ifdef SNAKE_CTRL_BLINK_EN
        exp_les = m_phase ? 8'h0F : 8'h00;
`else
        exp_les = 8'h00;
`endif
        chk("m_state", 32'(game_state_o), 32'(m_st));
        chk("m_tick",  32'(move_tick_o),  32'(m_tick));
        chk("m_score", 32'(score_bcd_o),  32'(to_bcd(m_score)));
        chk("m_high",  32'(high_bcd_o),   32'(to_bcd(m_high)));
        chk("m_level", 32'(level_o),      32'(m_level));
        chk("m_hexs",  disp_hexs_o,       {to_bcd(m_high), to_bcd(m_score)});
        chk("m_les",   32'(disp_les_o),   32'(exp_les));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: btn_start_i = 1'b1;
            1: btn_pause_i = 1'b1;
            2: get_food_i  = 1'b1;
            default: collision_i = 1'b1;
        endcase
        cyc(1);
        btn_start_i = 1'b0; btn_pause_i = 1'b0; get_food_i = 1'b0; collision_i = 1'b0;
    endtask

    task automatic foods(input int n);
        get_food_i = 1'b1;
        cyc(n);
        get_food_i = 1'b0;
    endtask

    // Cycles until the next move_tick, or -1 after a bounded wait.
    task automatic wait_tick(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (move_tick_o) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int k;

        #3 rst_ni = 1'b0;
        #19 rst_ni = 1'b1;
        cyc(1);
        chk("rst_state", 32'(game_state_o), 32'(GsIdle));
        chk("rst_score", 32'(score_bcd_o), 32'h0);
        chk("rst_high",  32'(high_bcd_o),  32'h0);
        chk("rst_level", 32'(level_o),     32'h0);
        chk("rst_tick",  32'(move_tick_o), 32'h0);
        chk("rst_les",   32'(disp_les_o),  32'h0);

        // Start, then three ticks in 30 cycles at level 0.
        pulse(0);
        chk("start_play", 32'(game_state_o), 32'(GsPlay));
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (move_tick_o) n++;
        end
        chk("ticks_30", 32'(n), 32'd3);

        // Seven foods: level saturates at 3, period 4.
        foods(7);
        chk("score_7", 32'(score_bcd_o), 32'h0007);
        chk("level_3", 32'(level_o), 32'd3);
        wait_tick(k);
        wait_tick(k);
        chk("period_l3", 32'(k), 32'd4);

        // High score latched on game over.
        pulse(3);
        chk("over_state", 32'(game_state_o), 32'(GsOver));
        chk("high_7", 32'(high_bcd_o), 32'h0007);
        pulse(0);
        chk("over_idle", 32'(game_state_o), 32'(GsIdle));

        // Async reset mid-play with score 5 drops everything, high included.
        pulse(0);
        foods(5);
        chk("score_5", 32'(score_bcd_o), 32'h0005);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_state", 32'(game_state_o), 32'(GsIdle));
        chk("arst_score", 32'(score_bcd_o), 32'h0);
        chk("arst_high",  32'(high_bcd_o),  32'h0);
        chk("arst_tick",  32'(move_tick_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1);

        // Pause at counter 6, no ticks while paused, tick 4 cycles after resume.
        pulse(0);
        cyc(6);
        pulse(1);
        chk("pause_state", 32'(game_state_o), 32'(GsPause));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (move_tick_o) n++;
        end
        chk("pause_noticks", 32'(n), 32'd0);
        pulse(1);
        chk("resume_state", 32'(game_state_o), 32'(GsPlay));
        wait_tick(k);
        chk("resume_tick", 32'(k), 32'd4);

        // Food and collision together: collision wins.
        foods(3);
        get_food_i = 1'b1;
        pulse(3);
        chk("fc_state", 32'(game_state_o), 32'(GsOver));
        chk("fc_score", 32'(score_bcd_o), 32'h0003);
        chk("fc_high",  32'(high_bcd_o),  32'h0003);
        pulse(0);
        pulse(0);
        foods(2);
        pulse(3);
        chk("low_state", 32'(game_state_o), 32'(GsOver));
        chk("low_high",  32'(high_bcd_o),  32'h0003);

`ifdef SNAKE_CTRL_BLINK_EN
        // Restart blink from a fresh OVER entry.
        pulse(0);
        pulse(0);
        pulse(3);
        for (int i = 0; i < 12; i++) begin
            chk("blink", 32'(disp_les_o), ((i / 4) % 2 == 1) ? 32'h0F : 32'h00);
            cyc(1);
        end
        pulse(0);
        chk("blink_idle", 32'(disp_les_o), 32'h00);
        pulse(0);
`else
        pulse(0);
        pulse(0);
`endif

        // BCD carries and saturation.
        foods(999);
        chk("score_0999", 32'(score_bcd_o), 32'h0999);
        foods(1);
        chk("score_1000", 32'(score_bcd_o), 32'h1000);
        foods(8999);
        chk("score_9999", 32'(score_bcd_o), 32'h9999);
        foods(1);
        chk("score_sat", 32'(score_bcd_o), 32'h9999);
        pulse(3);
        chk("high_9999", 32'(high_bcd_o), 32'h9999);
        pulse(0);

        // Random play, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            btn_start_i = ($urandom_range(0, 19) == 0);
            btn_pause_i = ($urandom_range(0, 14) == 0);
            get_food_i  = ($urandom_range(0, 2) == 0);
            collision_i = ($urandom_range(0, 59) == 0);
            cyc(1);
        end
        btn_start_i = 1'b0; btn_pause_i = 1'b0; get_food_i = 1'b0; collision_i = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
